// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: widths, limits and score-op decoding shared by the
// score, binary-to-decimal and display stages of the scoreboard path.
package scoreboard_pkg;
   localparam int SCORE_W           = 8;
   localparam int MAX_SCORE_DEFAULT = 99;
   localparam int DB_CNT_W          = 20;

   typedef enum logic [1:0] {OP_HOLD, OP_INC, OP_DEC, OP_CLR} score_op_e;

   // clear dominates; opposing inc/dec cancel out
   function automatic score_op_e decode_op(input logic inc, input logic dec, input logic clr);
      return clr ? OP_CLR : (inc && !dec) ? OP_INC : (dec && !inc) ? OP_DEC : OP_HOLD;
   endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-level debouncer and rising-edge
// pulse for one raw asynchronous push button.
module btn_debounce
   import scoreboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o
);
   logic [1:0]          sync;
   logic [DB_CNT_W-1:0] cnt;
   logic                db;
   logic                db_q;

   // the level is only accepted after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync <= '0;
         cnt  <= '0;
         db   <= 1'b0;
         db_q <= 1'b0;
      end else begin
         sync <= {sync[0], btn_i};
         db_q <= db;
         if (sync[1] == db) cnt <= '0;
         else if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db  <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end

   assign level_o = db;
   assign rise_o  = db & ~db_q;
endmodule

// File: rtl/score_counter.sv
// score_counter: debounced inc/dec/clear buttons driving a saturating
// 0..MAX_SCORE score with a one-cycle pulse on every actual change.
module score_counter
   import scoreboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_SCORE       = MAX_SCORE_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               inc_btn_i,
   input  logic               dec_btn_i,
   input  logic               clr_btn_i,
   output logic [SCORE_W-1:0] score_o,
   output logic               changed_o
);
   logic               inc_ev;
   logic               dec_ev;
   logic               clr_ev;
   score_op_e          op;
   logic [SCORE_W-1:0] next_score;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
      .clk_i(clk_i), .rst_i(rst_i), .btn_i(inc_btn_i), .level_o(), .rise_o(inc_ev)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
      .clk_i(clk_i), .rst_i(rst_i), .btn_i(dec_btn_i), .level_o(), .rise_o(dec_ev)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk_i(clk_i), .rst_i(rst_i), .btn_i(clr_btn_i), .level_o(), .rise_o(clr_ev)
   );

   // limits are checked before stepping, so 8-bit arithmetic never wraps
   always_comb begin
      op         = decode_op(inc_ev, dec_ev, clr_ev);
      next_score = op == OP_CLR ? '0 :
                   (op == OP_INC && score_o < SCORE_W'(MAX_SCORE)) ? score_o + 1'b1 :
                   (op == OP_DEC && score_o != '0) ? score_o - 1'b1 : score_o;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         score_o   <= '0;
         changed_o <= 1'b0;
      end else begin
         score_o   <= next_score;
         changed_o <= next_score != score_o;
      end
   end
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: scenario tasks plus randomized buttons checked against a
// sliding-window reference model of the debounced score.
module tb_score_counter;
   localparam int DB  = 4;
   localparam int MAX = 99;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inc = 1'b0;
   logic       dec = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] score;
   logic       changed;
   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;

   always #5 clk = ~clk;

   score_counter #(.DEBOUNCE_CYCLES(DB), .MAX_SCORE(MAX)) dut (
      .clk_i(clk), .rst_i(rst), .inc_btn_i(inc), .dec_btn_i(dec), .clr_btn_i(clr),
      .score_o(score), .changed_o(changed)
   );

   always @(posedge clk) if (changed === 1'b1) pulses++;

   // Reference: a button level is accepted once the last DB synchronised
   // samples (raw delayed two edges) all disagree with the accepted level.
   logic [2:0]    raw;
   logic [2:0]    r1, r2, lvl, ev;
   logic [DB-1:0] win [3];
   int            m_score = 0;
   int            nxt;
   logic          m_changed = 1'b0;
   assign raw = {clr, dec, inc};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_score = 0; m_changed = 1'b0;
         r1 = '0; r2 = '0; lvl = '0; ev = '0;
         for (int b = 0; b < 3; b++) win[b] = '0;
      end else begin
         nxt = ev[2] ? 0 :
               (ev[0] && !ev[1]) ? (m_score < MAX ? m_score + 1 : m_score) :
               (ev[1] && !ev[0]) ? (m_score > 0 ? m_score - 1 : m_score) : m_score;
         m_changed = nxt != m_score;
         m_score = nxt;
         for (int b = 0; b < 3; b++) begin
            win[b] = {win[b][DB-2:0], r2[b]};
            ev[b] = 1'b0;
            if (win[b] == {DB{~lvl[b]}}) begin
               lvl[b] = ~lvl[b];
               ev[b] = lvl[b];
            end
         end
         r2 = r1;
         r1 = raw;
      end
   end

   task automatic hold(input logic [2:0] v, input int n);
      {clr, dec, inc} = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] v);
      hold(v, 6);
      hold(3'b000, 8);
   endtask

   task automatic test_reset;
      int p0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (score !== 8'd0 || changed !== 1'b0) begin errors++; $display("FAIL reset_init score=%0d changed=%0b exp 0/0", score, changed); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      press(3'b001);
      checks++; if (score !== 8'd1) begin errors++; $display("FAIL reset_pre score=%0d exp 1", score); end
      hold(3'b001, 3);
      @(negedge clk) #2 rst = 1'b1;
      #1;
      checks++; if (score !== 8'd0 || changed !== 1'b0) begin errors++; $display("FAIL reset_async score=%0d changed=%0b exp 0/0", score, changed); end
      inc = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      p0 = pulses;
      hold(3'b000, 12);
      checks++; if (score !== 8'd0 || pulses != p0) begin errors++; $display("FAIL reset_drop score=%0d pulses=%0d exp 0/%0d", score, pulses, p0); end
      inc = 1'b1;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1;
      hold(3'b001, 10);
      hold(3'b000, 8);
      checks++; if (score !== 8'd1 || score !== 8'(m_score)) begin errors++; $display("FAIL reset_held score=%0d exp 1 model=%0d", score, m_score); end
   endtask

   task automatic test_single_inc;
      int s0;
      s0 = score;
      inc = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (score !== 8'(c >= 7 ? s0 + 1 : s0) || changed !== (c == 7)) begin
            errors++; $display("FAIL single_inc edge%0d score=%0d changed=%0b exp %0d/%0b", c, score, changed, c >= 7 ? s0 + 1 : s0, c == 7);
         end
         if (c == 10) inc = 1'b0;
      end
      @(posedge clk) #1;
      hold(3'b000, 6);
   endtask

   task automatic test_bounce;
      int s0, p0;
      s0 = score; p0 = pulses;
      hold(3'b001, 3); hold(3'b000, 1); hold(3'b001, 2); hold(3'b000, 10);
      checks++; if (score !== 8'(s0) || pulses != p0) begin errors++; $display("FAIL bounce_glitch score=%0d pulses=%0d exp %0d/%0d", score, pulses, s0, p0); end
      hold(3'b001, 6); hold(3'b000, 10);
      checks++; if (score !== 8'(s0 + 1) || pulses != p0 + 1) begin errors++; $display("FAIL bounce_clean score=%0d pulses=%0d exp %0d/%0d", score, pulses, s0 + 1, p0 + 1); end
   endtask

   task automatic test_saturation;
      int p0;
      press(3'b100);
      for (int i = 0; i < 120 && score < 8'(MAX); i++) press(3'b001);
      checks++; if (score !== 8'(MAX)) begin errors++; $display("FAIL sat_fill score=%0d exp %0d", score, MAX); end
      p0 = pulses;
      press(3'b001);
      checks++; if (score !== 8'(MAX) || pulses != p0) begin errors++; $display("FAIL sat_top score=%0d pulses=%0d exp %0d/%0d", score, pulses, MAX, p0); end
      press(3'b100);
      checks++; if (score !== 8'd0 || pulses != p0 + 1) begin errors++; $display("FAIL sat_clr score=%0d pulses=%0d exp 0/%0d", score, pulses, p0 + 1); end
      press(3'b010);
      checks++; if (score !== 8'd0 || pulses != p0 + 1) begin errors++; $display("FAIL sat_bottom score=%0d pulses=%0d exp 0/%0d", score, pulses, p0 + 1); end
   endtask

   task automatic test_simultaneous;
      int p0;
      for (int i = 0; i < 50; i++) press(3'b001);
      p0 = pulses;
      press(3'b011);
      checks++; if (score !== 8'd50 || pulses != p0) begin errors++; $display("FAIL sim_incdec score=%0d pulses=%0d exp 50/%0d", score, pulses, p0); end
      press(3'b101);
      checks++; if (score !== 8'd0 || pulses != p0 + 1) begin errors++; $display("FAIL sim_clrinc score=%0d pulses=%0d exp 0/%0d", score, pulses, p0 + 1); end
   endtask

   task automatic test_sequence;
      int p0;
      press(3'b100);
      for (int i = 0; i < 12; i++) press(3'b001);
      for (int i = 0; i < 3; i++) press(3'b010);
      checks++; if (score !== 8'd9) begin errors++; $display("FAIL seq_sum score=%0d exp 9", score); end
      p0 = pulses;
      press(3'b100);
      checks++; if (score !== 8'd0 || pulses != p0 + 1) begin errors++; $display("FAIL seq_clr score=%0d pulses=%0d exp 0/%0d", score, pulses, p0 + 1); end
      press(3'b100);
      checks++; if (score !== 8'd0 || pulses != p0 + 1) begin errors++; $display("FAIL seq_clr2 score=%0d pulses=%0d exp 0/%0d", score, pulses, p0 + 1); end
   endtask

   task automatic test_back_to_back;
      inc = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (score !== 8'(c == 7 ? 1 : 0) || changed !== (c == 7 || c == 8)) begin
            errors++; $display("FAIL b2b edge%0d score=%0d changed=%0b exp %0d/%0b", c, score, changed, c == 7 ? 1 : 0, c == 7 || c == 8);
         end
         if (c == 1) dec = 1'b1;
         if (c == 6) inc = 1'b0;
         if (c == 7) dec = 1'b0;
      end
      @(posedge clk) #1;
      hold(3'b000, 4);
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(5) == 0) inc = ~inc;
         if ($urandom_range(5) == 0) dec = ~dec;
         if ($urandom_range(24) == 0) clr = ~clr;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (score !== 8'(m_score) || changed !== m_changed) begin
            errors++; $display("FAIL random cyc%0d score=%0d changed=%0b exp %0d/%0b", c, score, changed, m_score, m_changed);
         end
      end
      @(posedge clk) #1;
      hold(3'b000, 10);
      checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL random_end score=%0d exp %0d", score, m_score); end
   endtask

   initial begin
      test_reset;
      test_single_inc;
      test_bounce;
      test_saturation;
      test_simultaneous;
      test_sequence;
      test_back_to_back;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
